// File: rtl/fu_sched.sv
// rtl/fu_sched.sv - three-FU issue/complete scheduler with dual round-robin writeback
module fu_sched #(
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           issue_valid,
    input  logic [3*TAG_W-1:0]   issue_tag,
    input  logic                 mem_done,
    input  logic                 flush,
    output logic [2:0]           fu_rdy,
    output logic [1:0]           wb_valid,
    output logic [2*TAG_W-1:0]   wb_tag,
    output logic [3:0]           wb_fu,
    output logic                 issue_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_WB = 2'd2
    } fu_state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    fu_state_t        r_state [3];
    fu_state_t        w_state_nxt [3];
    logic [3:0]       r_cnt [2];
    logic [3:0]       w_cnt_nxt [2];
    logic [TAG_W-1:0] r_tag [3];
    logic [TAG_W-1:0] w_tag_nxt [3];
    logic [1:0]       r_rr_ptr;
    logic [1:0]       w_rr_nxt;
    logic             r_issue_err;
    logic             w_issue_err_nxt;
    logic [2:0]       w_grant;
    logic [2:0]       w_exec_done;
    logic [2:0]       w_sum;
    logic [1:0]       w_idx;

    assign fu_rdy[0]   = (r_state[0] == S_IDLE);
    assign fu_rdy[1]   = (r_state[1] == S_IDLE);
    assign fu_rdy[2]   = (r_state[2] == S_IDLE);
    assign issue_err   = r_issue_err;
    assign w_exec_done = {mem_done, (r_cnt[1] == 4'd0), (r_cnt[0] == 4'd0)};

    // Walk FUs from r_rr_ptr; first WAIT_WB hit takes port 0, second takes port 1.
    always_comb begin
        w_grant  = '0;
        wb_valid = '0;
        wb_tag   = '0;
        wb_fu    = '0;
        w_rr_nxt = r_rr_ptr;
        w_sum    = '0;
        w_idx    = '0;
        if (!flush) begin
            for (int k = 0; k < 3; k++) begin
                w_sum = {1'b0, r_rr_ptr} + 3'(k);
                if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
                w_idx = w_sum[1:0];
                if (r_state[w_idx] == S_WAIT_WB) begin
                    if (!wb_valid[0]) begin
                        wb_valid[0]           = 1'b1;
                        wb_tag[TAG_W-1:0]     = r_tag[w_idx];
                        wb_fu[1:0]            = w_idx;
                        w_grant[w_idx]        = 1'b1;
                        w_rr_nxt              = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
                    end else if (!wb_valid[1]) begin
                        wb_valid[1]           = 1'b1;
                        wb_tag[2*TAG_W-1:TAG_W] = r_tag[w_idx];
                        wb_fu[3:2]            = w_idx;
                        w_grant[w_idx]        = 1'b1;
                        w_rr_nxt              = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_issue_err_nxt = r_issue_err;
        for (int i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tag_nxt[i]   = r_tag[i];
            if (flush) begin
                w_state_nxt[i] = S_IDLE;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        if (issue_valid[i]) begin
                            w_state_nxt[i] = S_EXEC;
                            w_tag_nxt[i]   = issue_tag[i*TAG_W +: TAG_W];
                        end
                    end
                    S_EXEC: begin
                        if (w_exec_done[i]) w_state_nxt[i] = S_WAIT_WB;
                    end
                    S_WAIT_WB: begin
                        if (w_grant[i]) w_state_nxt[i] = S_IDLE;
                    end
                    default: w_state_nxt[i] = S_IDLE;
                endcase
                if (issue_valid[i] && (r_state[i] != S_IDLE)) w_issue_err_nxt = 1'b1;
            end
        end
        for (int j = 0; j < 2; j++) begin
            w_cnt_nxt[j] = r_cnt[j];
            if (flush) begin
                w_cnt_nxt[j] = 4'd0;
            end else if ((r_state[j] == S_IDLE) && issue_valid[j]) begin
                w_cnt_nxt[j] = LAT_M1;
            end else if ((r_state[j] == S_EXEC) && (r_cnt[j] != 4'd0)) begin
                w_cnt_nxt[j] = r_cnt[j] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= S_IDLE;
                r_tag[i]   <= '0;
            end
            for (int j = 0; j < 2; j++) r_cnt[j] <= 4'd0;
            r_rr_ptr    <= 2'd0;
            r_issue_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
            end
            for (int j = 0; j < 2; j++) r_cnt[j] <= w_cnt_nxt[j];
            r_rr_ptr    <= w_rr_nxt;
            r_issue_err <= w_issue_err_nxt;
        end
    end

endmodule

// File: tb/tb_fu_sched.sv
// tb/tb_fu_sched.sv - directed vector bench for fu_sched (ALU_LAT 1 and 3 instances)
module tb_fu_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  issue_valid = '0;
    logic [17:0] issue_tag = '0;
    logic        mem_done = 1'b0;
    logic        flush = 1'b0;

    logic [2:0]  fu_rdy_a,   fu_rdy_b;
    logic [1:0]  wb_valid_a, wb_valid_b;
    logic [11:0] wb_tag_a,   wb_tag_b;
    logic [3:0]  wb_fu_a,    wb_fu_b;
    logic        issue_err_a, issue_err_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fu_sched #(.ALU_LAT(1), .TAG_W(6)) dut_a (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .mem_done(mem_done), .flush(flush), .fu_rdy(fu_rdy_a), .wb_valid(wb_valid_a),
        .wb_tag(wb_tag_a), .wb_fu(wb_fu_a), .issue_err(issue_err_a)
    );

    fu_sched #(.ALU_LAT(3), .TAG_W(6)) dut_b (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .mem_done(mem_done), .flush(flush), .fu_rdy(fu_rdy_b), .wb_valid(wb_valid_b),
        .wb_tag(wb_tag_b), .wb_fu(wb_fu_b), .issue_err(issue_err_b)
    );

    typedef struct packed {
        logic [2:0] iv;
        logic [5:0] t0, t1, t2;
        logic       md, fl;
        logic [2:0] rdy;
        logic [1:0] wbv;
        logic [5:0] wt0, wt1;
        logic [1:0] wf0, wf1;
        logic       err;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic [2:0] iv, input logic [5:0] t0, input logic [5:0] t1,
                                input logic [5:0] t2, input logic md, input logic fl,
                                input logic [2:0] rdy, input logic [1:0] wbv, input logic [5:0] wt0,
                                input logic [5:0] wt1, input logic [1:0] wf0, input logic [1:0] wf1,
                                input logic err);
        vec_t v;
        v.iv = iv; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.md = md; v.fl = fl;
        v.rdy = rdy; v.wbv = wbv; v.wt0 = wt0; v.wt1 = wt1; v.wf0 = wf0; v.wf1 = wf1; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    endtask

    task automatic drive(input logic [2:0] iv, input logic [5:0] t0, input logic [5:0] t1,
                         input logic [5:0] t2, input logic md, input logic fl);
        issue_valid = iv;
        issue_tag   = {t2, t1, t0};
        mem_done    = md;
        flush       = fl;
    endtask

    task automatic chk_a_idle(input string name, input int row);
        chk({name, "_rdy"}, row, 32'(fu_rdy_a), 32'h7);
        chk({name, "_wbv"}, row, 32'(wb_valid_a), 32'h0);
        chk({name, "_tag"}, row, 32'(wb_tag_a), 32'h0);
        chk({name, "_fu"},  row, 32'(wb_fu_a), 32'h0);
        chk({name, "_err"}, row, 32'(issue_err_a), 32'h0);
    endtask

    initial begin
        //            iv     t0 t1 t2 md fl  rdy     wbv   wt0 wt1 wf0 wf1 err
        vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 0);
        vecs[1]  = mk(3'b111, 1, 2, 3, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 0);
        vecs[2]  = mk(3'b000, 0, 0, 0, 1, 0, 3'b000, 2'b00, 0,  0,  0, 0, 0);
        vecs[3]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b000, 2'b11, 1,  2,  0, 1, 0);
        vecs[4]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b011, 2'b01, 3,  0,  2, 0, 0);
        vecs[5]  = mk(3'b101, 10, 0, 11, 0, 0, 3'b111, 2'b00, 0, 0, 0, 0, 0);
        vecs[6]  = mk(3'b000, 0, 0, 0, 1, 0, 3'b010, 2'b00, 0,  0,  0, 0, 0);
        vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b010, 2'b11, 10, 11, 0, 2, 0);
        vecs[8]  = mk(3'b001, 5, 0, 0, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 0);
        vecs[9]  = mk(3'b000, 0, 0, 0, 0, 0, 3'b110, 2'b00, 0,  0,  0, 0, 0);
        vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 3'b110, 2'b01, 5,  0,  0, 0, 0);
        vecs[11] = mk(3'b100, 0, 0, 4, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 0);
        vecs[12] = mk(3'b100, 0, 0, 7, 0, 0, 3'b011, 2'b00, 0,  0,  0, 0, 0);
        vecs[13] = mk(3'b000, 0, 0, 0, 0, 0, 3'b011, 2'b00, 0,  0,  0, 0, 1);
        vecs[14] = mk(3'b000, 0, 0, 0, 1, 0, 3'b011, 2'b00, 0,  0,  0, 0, 1);
        vecs[15] = mk(3'b000, 0, 0, 0, 0, 0, 3'b011, 2'b01, 4,  0,  2, 0, 1);
        vecs[16] = mk(3'b001, 20, 0, 0, 0, 0, 3'b111, 2'b00, 0, 0, 0, 0, 1);
        vecs[17] = mk(3'b000, 0, 0, 0, 0, 0, 3'b110, 2'b00, 0,  0,  0, 0, 1);
        vecs[18] = mk(3'b011, 20, 9, 0, 0, 1, 3'b110, 2'b00, 0, 0, 0, 0, 1);
        vecs[19] = mk(3'b000, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 1);
        vecs[20] = mk(3'b000, 0, 0, 0, 1, 0, 3'b111, 2'b00, 0,  0,  0, 0, 1);
        vecs[21] = mk(3'b000, 0, 0, 0, 0, 0, 3'b111, 2'b00, 0,  0,  0, 0, 1);

        // Outputs while reset is held.
        #2;
        chk_a_idle("reset", -1);
        @(posedge clk); #3 reset = 1'b1;

        for (int r = 0; r < 22; r++) begin
            @(posedge clk); #1;
            drive(vecs[r].iv, vecs[r].t0, vecs[r].t1, vecs[r].t2, vecs[r].md, vecs[r].fl);
            @(negedge clk);
            chk("rdy",  r, 32'(fu_rdy_a),       32'(vecs[r].rdy));
            chk("wbv",  r, 32'(wb_valid_a),     32'(vecs[r].wbv));
            chk("tag0", r, 32'(wb_tag_a[5:0]),  32'(vecs[r].wt0));
            chk("tag1", r, 32'(wb_tag_a[11:6]), 32'(vecs[r].wt1));
            chk("fu0",  r, 32'(wb_fu_a[1:0]),   32'(vecs[r].wf0));
            chk("fu1",  r, 32'(wb_fu_a[3:2]),   32'(vecs[r].wf1));
            chk("err",  r, 32'(issue_err_a),    32'(vecs[r].err));
        end

        // ALU_LAT=3 instance: FU1 tag 9 written back exactly 4 cycles after issue.
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0); reset = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1 drive(3'b010, 0, 9, 0, 0, 0);
        @(negedge clk);
        chk("lat3_wbv", 0, 32'(wb_valid_b), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("lat3_wbv", k, 32'(wb_valid_b), (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) begin
                chk("lat3_tag", k, 32'(wb_tag_b[5:0]), 32'd9);
                chk("lat3_fu",  k, 32'(wb_fu_b[1:0]),  32'd1);
                chk("lat3_rdy", k, 32'(fu_rdy_b),      32'h5);
            end
        end
        chk("lat3_rdy_after", 5, 32'(fu_rdy_b), 32'h7);

        // Reset while FU2 is executing, then a stray mem_done after release.
        @(posedge clk); #1 drive(3'b100, 0, 0, 7, 0, 0);
        @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_mid_busy", 0, 32'(fu_rdy_a), 32'h3);
        #1 reset = 1'b0;
        #1 chk_a_idle("rst_async", 1);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1 drive(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rst_md_wbv", 2, 32'(wb_valid_a), 32'h0);
        for (int k = 3; k < 6; k++) begin
            @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk_a_idle("rst_after", k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
